mmio_seg_scan: RTL and testbench
================================

Name: mmio_seg_scan

Overview:
- Parametrised memory-mapped seven-segment display controller. It succeeds the fixed 8-digit tube driver.
- Sits on the CPU IO bus beside the LED and switch peripherals, selected by the memorio decoder's chip-select.
- Holds per-digit hex data, decimal-point, enable and control registers, and time-multiplexes DIGITS common-anode digits with a programmable scan rate.
- Register reads return live state to the single-cycle core.

Parameters:
- DIGITS, 8: number of digits scanned; legal range 1..8, since data packs 4 bits per digit into 32 bits.
- SCAN_DIV, 100000: clock cycles each digit stays selected; must be at least 2.
- BLINK_DIV, 256: full scan rounds per blink half-period; used only with the optional feature.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cs  input  1  chip-select from the address decoder.
- write  input  1  register write strobe, qualified by cs.
- read  input  1  register read strobe, qualified by cs.
- addr  input  3  register word index.
- wdata  input  32  write data.
- rdata  output  32  read data; combinational, 0 when !(cs&&read).
- seg_out  output  8  segments, active-low; bit7 = dp, bits6..0 = g..a.
- dig_sel  output  DIGITS  digit selects, active-low, at most one low.

Behaviour:
- Register map:
  - 0 DATA: nibble i (bits 4i+3..4i) = digit i; bits above 4*DIGITS read 0.
  - 1 DP: bit i lights dp of digit i.
  - 2 ENABLE: bit i = 0 blanks digit i.
  - 3 CTRL: bit0 = display on.
  - 4 STATUS: read-only; bits 2..0 = current scan index.
  - 5 BLINK: see optional feature.
  - 6, 7: reserved; read 0, writes ignored.
- Reset values: DATA=0, DP=0, ENABLE=all ones, CTRL=1, prescaler=0, index=0, seg_out=8'hFF, dig_sel=all ones.
- Writes take effect on the rising edge where cs&&write. Unused bits of DP/ENABLE/BLINK (above DIGITS-1) are dropped. Writes to STATUS are ignored.
- Reads are combinational from the register state. A read and write in the same cycle returns the old value.
- Prescaler counts 0..SCAN_DIV-1 and wraps to 0. On the cycle it is at SCAN_DIV-1, index advances; DIGITS-1 wraps to 0.
- Output registers update every clock from the current index.
  - Digit visible when: CTRL.bit0 && ENABLE[index] && not blink-suppressed.
  - Visible: dig_sel = all ones except bit index low; seg_out = hexdecode(DATA nibble), with bit7 cleared when DP[index].
  - Not visible: dig_sel = all ones, seg_out = 8'hFF.
- Output latency: one clock after an index or register change.
- Hex decode (active-low, dp excluded): 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- Anti-ghost: on the cycle the index advances, the outputs for that cycle are forced blank (dig_sel all ones, seg_out FF). Each digit is therefore lit SCAN_DIV-1 cycles per slot.
- DIGITS=1: index stays 0; the anti-ghost blank cycle still occurs every SCAN_DIV cycles.
- Mid-operation reset: all state returns to reset values immediately, without waiting for a clock edge.
- Clearing CTRL.bit0 blanks the outputs on the next edge but scanning continues, so the index keeps advancing.

Optional Feature:
- Macro TUBE_SEG_BLINK_EN.
- When defined:
  - Register 5 BLINK holds a per-digit mask and CTRL.bit1 is blink enable; both reset to 0.
  - A blink counter counts index wraps (DIGITS-1 -> 0) and toggles a phase bit every BLINK_DIV wraps. Phase resets to 0, meaning shown.
  - A digit with BLINK[i] && CTRL.bit1 && phase=1 is blanked.
- When undefined:
  - No blink counter is built.
  - Register 5 and CTRL.bit1 read 0; writes to them are ignored.

Test Plan (DIGITS=8, SCAN_DIV=4, BLINK_DIV=2):
- Reset release -> seg_out=FF, dig_sel=FF. On the next edge dig_sel=FE and seg_out=C0. STATUS reads 0 until the 4th cycle, then 1.
- Write DATA=32'h76543210 and DP=8'h01 -> digit0 shows seg 40 (C0 with dp), digit1 shows F9, digit7 shows F8. Each digit is low on dig_sel for 3 cycles followed by 1 blank cycle; the index wraps 7->0.
- Write ENABLE=8'hFE -> during slot 0, dig_sel=FF and seg_out=FF; slot 1 is unaffected. Write CTRL=0 -> all slots blank while STATUS keeps advancing.
- Read addr 6 -> rdata=0. Assert reset mid-slot 5 -> outputs go FF immediately; STATUS reads 0 after reset.
- With TUBE_SEG_BLINK_EN defined: write BLINK=8'h04 and CTRL=3 -> digit2 is lit for 2 scan rounds, blank for 2, and repeats; the other digits stay lit.
- With TUBE_SEG_BLINK_EN undefined, the same writes -> CTRL reads 1, BLINK reads 0, and digit2 never blanks.

Source files
------------

// File: rtl/mmio_seg_scan_if.sv
// mmio_seg_scan_if: CPU IO-bus port of the seven-segment scan controller.
interface mmio_seg_scan_if;
    logic        cs;
    logic        write;
    logic        read;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output cs, write, read, addr, wdata, input rdata);
    modport slave  (input cs, write, read, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_seg_scan.sv
// mmio_seg_scan: memory-mapped, time-multiplexed common-anode seven-segment driver.
// Define TUBE_SEG_BLINK_EN to build the per-digit blink register and blink counter.
module mmio_seg_scan #(
    parameter int DIGITS    = 8,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 256
) (
    input  logic              clock,
    input  logic              reset,
    mmio_seg_scan_if.slave    bus,
    output logic [7:0]        seg_out,
    output logic [DIGITS-1:0] dig_sel
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [7:0] MASK = 8'((1 << DIGITS) - 1);
    localparam logic [31:0] DMASK = 32'((64'd1 << (4 * DIGITS)) - 64'd1);
    localparam logic [2:0] LAST = 3'(DIGITS - 1);
    localparam logic [PW-1:0] PLAST = PW'(SCAN_DIV - 1);
    localparam logic [7:0] HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic [31:0]   data_q;
    logic [7:0]    dp_q, en_q;
    logic          on_q;
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          wr, adv, vis, blink_off, blink_en_rd;
    logic [7:0]    blink_rd, seg_d;
    logic [3:0]    nib;

    assign wr  = bus.cs && bus.write;
    assign adv = presc == PLAST;

`ifdef TUBE_SEG_BLINK_EN
    logic [7:0]    blink_q;
    logic          blink_en_q, phase;
    logic [BW-1:0] bcnt;

    // Phase flips every BLINK_DIV full scan rounds; phase 1 hides masked digits.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_q    <= '0;
            blink_en_q <= 1'b0;
            phase      <= 1'b0;
            bcnt       <= '0;
        end else begin
            if (wr && bus.addr == 3'd5) blink_q <= bus.wdata[7:0] & MASK;
            if (wr && bus.addr == 3'd3) blink_en_q <= bus.wdata[1];
            if (adv && idx == LAST) begin
                bcnt <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + 1'b1;
                if (bcnt == BW'(BLINK_DIV - 1)) phase <= ~phase;
            end
        end
    end

    assign blink_off   = blink_q[idx] && blink_en_q && phase;
    assign blink_rd    = blink_q;
    assign blink_en_rd = blink_en_q;
`else
    assign blink_off   = 1'b0;
    assign blink_rd    = '0;
    assign blink_en_rd = 1'b0;
`endif

    assign nib   = data_q[{idx, 2'b00} +: 4];
    assign seg_d = {~dp_q[idx], HEX[nib][6:0]};
    // The advance cycle is forced dark so the old pattern never ghosts onto the next digit.
    assign vis   = on_q && en_q[idx] && !adv && !blink_off;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            dp_q    <= '0;
            en_q    <= MASK;
            on_q    <= 1'b1;
            presc   <= '0;
            idx     <= '0;
            seg_out <= 8'hFF;
            dig_sel <= '1;
        end else begin
            if (wr && bus.addr == 3'd0) data_q <= bus.wdata & DMASK;
            if (wr && bus.addr == 3'd1) dp_q <= bus.wdata[7:0] & MASK;
            if (wr && bus.addr == 3'd2) en_q <= bus.wdata[7:0] & MASK;
            if (wr && bus.addr == 3'd3) on_q <= bus.wdata[0];
            presc <= adv ? '0 : presc + 1'b1;
            if (adv) idx <= idx == LAST ? 3'd0 : idx + 3'd1;
            seg_out <= vis ? seg_d : 8'hFF;
            dig_sel <= vis ? ~(DIGITS'(1) << idx) : '1;
        end
    end

    always_comb begin
        bus.rdata = !(bus.cs && bus.read) ? 32'd0 :
                    bus.addr == 3'd0 ? data_q :
                    bus.addr == 3'd1 ? {24'd0, dp_q} :
                    bus.addr == 3'd2 ? {24'd0, en_q} :
                    bus.addr == 3'd3 ? {30'd0, blink_en_rd, on_q} :
                    bus.addr == 3'd4 ? {29'd0, idx} :
                    bus.addr == 3'd5 ? {24'd0, blink_rd} : 32'd0;
    end
endmodule

// File: tb/tb_mmio_seg_scan.sv
// tb_mmio_seg_scan: random bus traffic against a time-indexed behavioural model of the scanner.
module tb_mmio_seg_scan;
    localparam int D  = 8;
    localparam int SD = 4;
    localparam int BD = 2;
    localparam logic [7:0] HEXM [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic         clock, reset;
    logic [7:0]   seg_out;
    logic [D-1:0] dig_sel;
    mmio_seg_scan_if bus ();

    mmio_seg_scan #(.DIGITS(D), .SCAN_DIV(SD), .BLINK_DIV(BD)) u_dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .seg_out (seg_out),
        .dig_sel (dig_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: state is the number of edges since reset plus shadow registers.
    int         n;
    logic [31:0] data_m;
    logic [7:0]  dp_m, en_m, blink_m;
    logic        on_m, ben_m;
    logic [7:0]  exp_seg;
    logic [7:0]  exp_dig;

    function automatic int idx_at(int k);
        return (k / SD) % D;
    endfunction

    function automatic logic vis_at(int k);
        int i;
        logic v;
        i = idx_at(k);
        v = on_m && en_m[i] && (k % SD != SD - 1);
`ifdef TUBE_SEG_BLINK_EN
        if (blink_m[i] && ben_m && ((k / (SD * D)) / BD) % 2 == 1) v = 1'b0;
`endif
        return v;
    endfunction

    function automatic logic [7:0] seg_at(int k);
        int i;
        i = idx_at(k);
        return vis_at(k) ? {~dp_m[i], HEXM[data_m[4*i +: 4]][6:0]} : 8'hFF;
    endfunction

    function automatic logic [7:0] dig_at(int k);
        logic [7:0] one;
        one = 8'd1;
        return vis_at(k) ? ~(one << idx_at(k)) : 8'hFF;
    endfunction

    function automatic logic [31:0] rd_exp(logic [2:0] a);
        case (a)
            3'd0: return data_m;
            3'd1: return {24'd0, dp_m};
            3'd2: return {24'd0, en_m};
            3'd3: return {30'd0, ben_m, on_m};
            3'd4: return 32'(idx_at(n));
            3'd5: return {24'd0, blink_m};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n <= 0; data_m <= 0; dp_m <= 0; en_m <= 8'hFF; on_m <= 1'b1;
            ben_m <= 1'b0; blink_m <= 8'h00; exp_seg <= 8'hFF; exp_dig <= 8'hFF;
        end else begin
            exp_seg <= seg_at(n);
            exp_dig <= dig_at(n);
            n <= n + 1;
            if (bus.cs && bus.write) begin
                case (bus.addr)
                    3'd0: data_m <= bus.wdata;
                    3'd1: dp_m <= bus.wdata[7:0];
                    3'd2: en_m <= bus.wdata[7:0];
                    3'd3: begin
                        on_m <= bus.wdata[0];
`ifdef TUBE_SEG_BLINK_EN
                        ben_m <= bus.wdata[1];
`endif
                    end
`ifdef TUBE_SEG_BLINK_EN
                    3'd5: blink_m <= bus.wdata[7:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        chk("seg_out", 32'(seg_out), 32'(exp_seg));
        chk("dig_sel", 32'(dig_sel), 32'(exp_dig));
        chk("rdata", bus.rdata, (bus.cs && bus.read) ? rd_exp(bus.addr) : 32'd0);
    end

    task automatic idle();
        bus.cs = 0; bus.write = 0; bus.read = 0; bus.addr = 0; bus.wdata = 0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.cs = 1; bus.write = 1; bus.read = 0; bus.addr = a; bus.wdata = d;
        @(posedge clock); #2;
        idle();
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.cs = 1; bus.read = 1; bus.write = 0; bus.addr = a;
        #1 chk(name, bus.rdata, exp);
        idle();
    endtask

    task automatic wait_dig(input logic [7:0] target);
        bit found;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clock);
            if (dig_sel == target) found = 1;
        end
        if (!found) begin
            total++;
            $display("FAIL wait_dig: dig_sel never reached %h", target);
        end
    endtask

    task automatic count_round(input logic [7:0] target, input int cycles, output int hits);
        hits = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            if (dig_sel == target) hits++;
        end
    endtask

    initial begin
        int c0, c1;
        idle();
        reset = 1;
        repeat (2) @(posedge clock);
        #2 reset = 0;
        chk("rst_seg", 32'(seg_out), 32'hFF);
        chk("rst_dig", 32'(dig_sel), 32'hFF);
        @(posedge clock); #2;
        chk("first_dig", 32'(dig_sel), 32'hFE);
        chk("first_seg", 32'(seg_out), 32'hC0);
        rd_chk("status_n1", 3'd4, 32'd0);
        repeat (2) @(posedge clock); #2;
        rd_chk("status_n3", 3'd4, 32'd0);
        @(posedge clock); #2;
        rd_chk("status_n4", 3'd4, 32'd1);

        bus_write(3'd0, 32'h76543210);
        bus_write(3'd1, 32'h01);
        wait_dig(8'h7F);
        chk("d7_seg", 32'(seg_out), 32'hF8);
        wait_dig(8'hFE);
        chk("d0_seg", 32'(seg_out), 32'h40);
        @(negedge clock); chk("d0_lit2", 32'(dig_sel), 32'hFE);
        @(negedge clock); chk("d0_lit3", 32'(dig_sel), 32'hFE);
        @(negedge clock); chk("ghost_dig", 32'(dig_sel), 32'hFF);
        chk("ghost_seg", 32'(seg_out), 32'hFF);
        @(negedge clock); chk("d1_dig", 32'(dig_sel), 32'hFD);
        chk("d1_seg", 32'(seg_out), 32'hF9);

        @(posedge clock); #2;
        bus_write(3'd2, 32'hFE);
        count_round(8'hFE, SD * D, c0);
        count_round(8'hFD, SD * D, c1);
        chk("en_slot0", 32'(c0), 32'd0);
        chk("en_slot1", 32'(c1), 32'd3);
        @(posedge clock); #2;
        bus_write(3'd3, 32'h0);
        count_round(8'hFF, SD * D, c0);
        chk("off_blank", 32'(c0), SD * D);
        @(posedge clock); #2;
        bus_write(3'd2, 32'hFF);
        bus_write(3'd3, 32'h1);
        bus_write(3'd6, 32'hDEADBEEF);
        rd_chk("rsvd6", 3'd6, 32'd0);
        rd_chk("rsvd7", 3'd7, 32'd0);

        wait_dig(8'hDF);
        #1 reset = 1;
        #1 chk("arst_seg", 32'(seg_out), 32'hFF);
        chk("arst_dig", 32'(dig_sel), 32'hFF);
        rd_chk("arst_status", 3'd4, 32'd0);
        @(posedge clock); #2 reset = 0;

        bus_write(3'd0, 32'h76543210);
        bus_write(3'd5, 32'h04);
        bus_write(3'd3, 32'h3);
`ifdef TUBE_SEG_BLINK_EN
        rd_chk("ctrl_rd", 3'd3, 32'd3);
        rd_chk("blink_rd", 3'd5, 32'h04);
        count_round(8'hFB, SD * D * 2 * BD, c0);
        chk("blink_d2", 32'(c0), 32'((SD - 1) * BD));
`else
        rd_chk("ctrl_rd", 3'd3, 32'd1);
        rd_chk("blink_rd", 3'd5, 32'd0);
        count_round(8'hFB, SD * D * 2 * BD, c0);
        chk("blink_d2", 32'(c0), 32'((SD - 1) * 2 * BD));
`endif
        count_round(8'hFD, SD * D * 2 * BD, c1);
        chk("blink_d1", 32'(c1), 32'((SD - 1) * 2 * BD));

        for (int i = 0; i < 1500; i++) begin
            @(posedge clock); #2;
            if (i == 700) begin
                #1 reset = 1;
                #3 reset = 0;
            end
            bus.cs    = $urandom_range(0, 3) != 0;
            bus.write = $urandom_range(0, 5) == 0;
            bus.read  = $urandom_range(0, 1) == 1;
            bus.addr  = 3'($urandom_range(0, 7));
            bus.wdata = $urandom;
            if (bus.addr == 3'd3) bus.wdata[0] = $urandom_range(0, 3) != 0;
            if (bus.addr == 3'd2 && $urandom_range(0, 1) == 1) bus.wdata[7:0] = 8'hFF;
        end
        @(posedge clock); #2;
        idle();
        repeat (4) @(posedge clock);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
